// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the per-frame move scheduler.
//   - coordinate widths of the playfield
//   - bit positions inside the 4-bit collision state
//   - result forced on a player whose query was never acknowledged
//   - scheduler FSM encoding
package move_scheduler_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    localparam int unsigned COL_UP    = 0;  // standing on ground
    localparam int unsigned COL_DOWN  = 1;  // touching ceiling
    localparam int unsigned COL_RIGHT = 2;
    localparam int unsigned COL_LEFT  = 3;

    // Blocked on every side: the mover leaves the player where it is.
    localparam logic [3:0] COL_FREEZE = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StQ1,
        StW1,
        StM1,
        StQ2,
        StW2,
        StM2,
        StDone
    } state_e;

endpackage

// File: rtl/move_scheduler_ack_timer.sv
// Wait counter for one outstanding collision query.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count (held while the query is being issued)
//   en         : one wait cycle elapses
//   expired    : high during the LIMIT-th wait cycle without an ack
// LIMIT must lie in 1..32; the 5-bit count saturates at 31.
module move_scheduler_ack_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [4:0] LastCnt = 5'(LIMIT - 1);

    logic [4:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= 5'd0;
        end else if (en && cnt_q != 5'h1f) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // cnt_q counts completed wait cycles, so this flags the last allowed one.
    assign expired = en && (cnt_q >= LastCnt);

endmodule

// File: rtl/move_scheduler.sv
// Per-frame scheduler sharing one collision-query unit between two players.
// Each accepted frame_tick runs one query per player, latches the result and
// strobes that player's move enable, then pulses frame_done.
//   clk, rst_n          : clock, synchronous active-low reset
//   frame_tick, pause   : frame start pulse, level that suppresses new frames
//   blue_x/y, red_x/y   : current player coordinates
//   col_req/x/y         : query to the collision unit, held until answered
//   col_ack, col_state  : single-cycle answer from the collision unit
//   blue/red_col_state  : latched per-player collision result
//   blue/red_move_en    : one-cycle mover update strobes
//   busy, frame_done    : sequence in progress, end-of-frame pulse
//   overrun, timeout_err: sticky error flags
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter bit          ALTERNATE   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           pause,
    input  logic [X_W-1:0] blue_x,
    input  logic [Y_W-1:0] blue_y,
    input  logic [X_W-1:0] red_x,
    input  logic [Y_W-1:0] red_y,
    output logic           col_req,
    output logic [X_W-1:0] col_x,
    output logic [Y_W-1:0] col_y,
    input  logic           col_ack,
    input  logic [3:0]     col_state,
    output logic [3:0]     blue_col_state,
    output logic [3:0]     red_col_state,
    output logic           blue_move_en,
    output logic           red_move_en,
    output logic           busy,
    output logic           frame_done,
    output logic           overrun,
    output logic           timeout_err
);

    state_e     state_q;
    logic       first_red_q;  // player served first this frame (0 = blue)
    logic       cur_red_q;    // player owning the outstanding query
    logic       serve_red;
    logic [3:0] result;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_expired;

    assign serve_red = (state_q == StQ1) ? first_red_q : ~first_red_q;
    assign result    = col_ack ? col_state : COL_FREEZE;
    assign tmr_clear = (state_q == StQ1) || (state_q == StQ2);
    assign tmr_en    = (state_q == StW1) || (state_q == StW2);
    assign busy      = (state_q != StIdle);

    move_scheduler_ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            first_red_q    <= 1'b0;
            cur_red_q      <= 1'b0;
            col_req        <= 1'b0;
            col_x          <= '0;
            col_y          <= '0;
            blue_col_state <= 4'd0;
            red_col_state  <= 4'd0;
            blue_move_en   <= 1'b0;
            red_move_en    <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            blue_move_en <= 1'b0;
            red_move_en  <= 1'b0;
            frame_done   <= 1'b0;

            // Includes the DONE cycle, so a tick racing DONE->IDLE is dropped.
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (frame_tick && !pause) begin
                        state_q <= StQ1;
                    end
                end
                StQ1, StQ2: begin
                    // Coordinates are captured once and held for the whole query.
                    cur_red_q <= serve_red;
                    col_x     <= serve_red ? red_x : blue_x;
                    col_y     <= serve_red ? red_y : blue_y;
                    col_req   <= 1'b1;
                    state_q   <= (state_q == StQ1) ? StW1 : StW2;
                end
                StW1, StW2: begin
                    if (col_ack || tmr_expired) begin
                        if (cur_red_q) begin
                            red_col_state <= result;
                        end else begin
                            blue_col_state <= result;
                        end
                        if (!col_ack) begin
                            timeout_err <= 1'b1;
                        end
                        col_req <= 1'b0;
                        state_q <= (state_q == StW1) ? StM1 : StM2;
                    end
                end
                StM1, StM2: begin
                    blue_move_en <= ~cur_red_q;
                    red_move_en  <= cur_red_q;
                    state_q      <= (state_q == StM1) ? StQ2 : StDone;
                end
                StDone: begin
                    frame_done <= 1'b1;
                    if (ALTERNATE) begin
                        first_red_q <= ~first_red_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: each started frame pushes the two
// expected player services; the monitor pops one per move-enable strobe.
module tb_move_scheduler;
    import move_scheduler_pkg::*;

    localparam int unsigned AckTimeout = 16;
    localparam logic [X_W-1:0] BlueX = 10'd100;
    localparam logic [X_W-1:0] RedX  = 10'd300;
    localparam logic [Y_W-1:0] BlueY = 9'd50;
    localparam logic [Y_W-1:0] RedY  = 9'd200;
    localparam int InjNone  = 0;
    localparam int InjTick  = 1;
    localparam int InjPause = 2;
    localparam int InjCoord = 3;

    typedef struct {
        logic           red;
        logic [3:0]     cs;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        int             len;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           frame_tick;
    logic           pause;
    logic [X_W-1:0] blue_x;
    logic [Y_W-1:0] blue_y;
    logic [X_W-1:0] red_x;
    logic [Y_W-1:0] red_y;
    logic           col_req;
    logic [X_W-1:0] col_x;
    logic [Y_W-1:0] col_y;
    logic           col_ack;
    logic [3:0]     col_state;
    logic [3:0]     blue_col_state;
    logic [3:0]     red_col_state;
    logic           blue_move_en;
    logic           red_move_en;
    logic           busy;
    logic           frame_done;
    logic           overrun;
    logic           timeout_err;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         frames   = 0;
    int         d_blue   = 0;   // ack delay in wait cycles, -1 = never
    int         d_red    = 0;
    int         stray    = 0;   // ack while no request is outstanding
    int         wcnt     = 0;
    int         cur_len  = 0;
    int         last_len = 0;
    logic       prev_req = 1'b0;
    logic       first_red = 1'b0;
    logic [3:0] blue_resp;
    logic [3:0] red_resp;

    move_scheduler #(
        .ACK_TIMEOUT(AckTimeout),
        .ALTERNATE  (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .pause         (pause),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .red_x         (red_x),
        .red_y         (red_y),
        .col_req       (col_req),
        .col_x         (col_x),
        .col_y         (col_y),
        .col_ack       (col_ack),
        .col_state     (col_state),
        .blue_col_state(blue_col_state),
        .red_col_state (red_col_state),
        .blue_move_en  (blue_move_en),
        .red_move_en   (red_move_en),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq(tag, 64'({col_req, col_x, col_y, blue_col_state, red_col_state, blue_move_en,
                           red_move_en, busy, frame_done, overrun, timeout_err}), 64'd0);
    endtask

    function automatic int wait_cycles(input int d);
        return (d < 0) ? int'(AckTimeout) : d + 1;
    endfunction

    function automatic exp_t make_exp(input logic red);
        exp_t e;
        int   d;
        d     = red ? d_red : d_blue;
        e.red = red;
        e.x   = red ? RedX : BlueX;
        e.y   = red ? RedY : BlueY;
        e.cs  = (d < 0) ? 4'b1111 : (red ? red_resp : blue_resp);
        e.len = wait_cycles(d);
        return e;
    endfunction

    // Starts one frame and waits for frame_done; latency counted in edges from
    // the edge that samples frame_tick.
    task automatic run_frame(input string name, input int inject);
        int lat;
        int exp_lat;
        exp_lat = 5 + wait_cycles(d_blue) + wait_cycles(d_red);
        sb.push_back(make_exp(first_red));
        sb.push_back(make_exp(!first_red));
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (frame_done || lat >= 200) break;
            @(posedge clk); #1;
            lat++;
            frame_tick = (inject == InjTick && lat == 1);
            if (inject == InjPause && lat == 4) pause = 1'b1;
            if (inject == InjCoord && lat == 1) begin
                red_x = 10'd555;
                red_y = 9'd7;
            end
        end
        check_eq({name, "_latency"}, 64'(lat), 64'(exp_lat));
        first_red = !first_red;
        frames++;
    endtask

    // Collision unit model: answers after a per-player delay.
    initial begin
        col_ack   = 1'b0;
        col_state = 4'b1010;
        forever begin
            @(posedge clk); #1;
            col_ack   = 1'b0;
            col_state = 4'b1010;
            if (col_req) begin
                if (col_x == BlueX) begin
                    if (d_blue >= 0 && wcnt == d_blue) begin
                        col_ack   = 1'b1;
                        col_state = blue_resp;
                    end
                end else if (d_red >= 0 && wcnt == d_red) begin
                    col_ack   = 1'b1;
                    col_state = red_resp;
                end
                wcnt++;
            end else begin
                wcnt = 0;
                if (stray != 0) begin
                    col_ack   = 1'b1;
                    col_state = 4'b0110;
                end
            end
        end
    end

    // Monitor: query coordinates, request length and service order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (col_req) begin
                cur_len++;
                if (sb.size() == 0) begin
                    check_eq("req_unexpected", 64'(col_req), 64'd0);
                end else begin
                    check_eq("col_x", 64'(col_x), 64'(sb[0].x));
                    check_eq("col_y", 64'(col_y), 64'(sb[0].y));
                end
            end else if (prev_req) begin
                last_len = cur_len;
                cur_len  = 0;
            end
            prev_req = col_req;
            if (blue_move_en || red_move_en) begin
                check_eq("move_excl", 64'(blue_move_en && red_move_en), 64'd0);
                if (sb.size() == 0) begin
                    check_eq("move_unexpected", 64'({blue_move_en, red_move_en}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("order", 64'(red_move_en), 64'(e.red));
                    check_eq("col_state", 64'(e.red ? red_col_state : blue_col_state),
                             64'(e.cs));
                    check_eq("req_len", 64'(last_len), 64'(e.len));
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        pause      = 1'b0;
        blue_x     = BlueX;
        blue_y     = BlueY;
        red_x      = RedX;
        red_y      = RedY;
        blue_resp  = 4'(1 << COL_UP);
        red_resp   = 4'(1 << COL_RIGHT);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset_outs");
        rst_n = 1'b1;

        // Three frames: ack delays and alternating service order.
        d_blue = 2;
        d_red  = 2;
        run_frame("fa", InjNone);
        check_eq("fa_blue_cs", 64'(blue_col_state), 64'h1);
        check_eq("fa_red_cs", 64'(red_col_state), 64'h4);
        check_eq("fa_done", 64'(done_cnt), 64'd1);

        d_blue    = 0;
        d_red     = 0;
        blue_resp = 4'(1 << COL_LEFT);
        red_resp  = 4'(1 << COL_DOWN);
        run_frame("fb", InjNone);

        stray     = 1;
        blue_resp = 4'b0101;
        red_resp  = 4'b1001;
        run_frame("fc", InjNone);
        stray = 0;
        check_eq("fc_done", 64'(done_cnt), 64'd3);

        // Tick while paused is ignored.
        pause = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("pause_busy", 64'(busy), 64'd0);
        check_eq("pause_overrun", 64'(overrun), 64'd0);
        check_eq("pause_done", 64'(done_cnt), 64'd3);
        pause = 1'b0;

        // Tick during the first wait: dropped, overrun set.
        run_frame("fd", InjTick);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_eq("fd_overrun", 64'(overrun), 64'd1);
        check_eq("fd_busy", 64'(busy), 64'd0);
        check_eq("fd_done", 64'(done_cnt), 64'd4);
        check_eq("fd_sb_drained", 64'(sb.size()), 64'd0);

        // Pause raised mid-frame: frame still completes.
        run_frame("fe", InjPause);
        check_eq("fe_done", 64'(done_cnt), 64'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("fe_idle", 64'(busy), 64'd0);
        pause = 1'b0;

        // Reset while the first query is outstanding (red served first here).
        d_blue = -1;
        d_red  = -1;
        sb.push_back(make_exp(first_red));
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_req", 64'(col_req), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outs_zero("abort_outs");
        rst_n = 1'b1;
        sb.delete();
        first_red = 1'b0;

        // Blue never answered: timeout, blue frozen, red still served.
        d_blue   = -1;
        d_red    = 0;
        red_resp = 4'b0011;
        run_frame("ff", InjNone);
        check_eq("ff_blue_cs", 64'(blue_col_state), 64'(COL_FREEZE));
        check_eq("ff_red_cs", 64'(red_col_state), 64'h3);
        check_eq("ff_timeout", 64'(timeout_err), 64'd1);

        // Coordinates change during an outstanding query.
        d_blue    = 1;
        d_red     = 1;
        blue_resp = 4'b0010;
        red_resp  = 4'b1000;
        run_frame("fh", InjCoord);
        red_x = RedX;
        red_y = RedY;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("total_done", 64'(done_cnt), 64'(frames));
        check_eq("final_sb", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Per-frame controller that time-multiplexes one shared collision-query unit between the blue and red players.
- On each frame tick it runs one collision query per player, latches the 4-bit collision state and pulses that player's move-enable so the mover module updates x/y/speed exactly once per frame.
- Sits between the VGA frame-tick source, the collision unit and the two per-player move modules.

Parameters:
- ACK_TIMEOUT, 16: max cycles to wait for col_ack before forcing a timeout result.
- ALTERNATE, 1: 1 = swap which player is served first on every frame; 0 = blue always first.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per physics frame
- pause  in  1  level; suppresses new frames
- blue_x  in  10  blue player current x
- blue_y  in  9  blue player current y
- red_x  in  10  red player current x
- red_y  in  9  red player current y
- col_req  out  1  query request to collision unit
- col_x  out  10  query x, stable while col_req=1
- col_y  out  9  query y, stable while col_req=1
- col_ack  in  1  collision unit result valid (single cycle)
- col_state  in  4  [0]=up/ground [1]=down/ceiling [2]=right [3]=left
- blue_col_state  out  4  latched blue collision result
- red_col_state  out  4  latched red collision result
- blue_move_en  out  1  one-cycle update strobe for blue mover
- red_move_en  out  1  one-cycle update strobe for red mover
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when both players are updated
- overrun  out  1  sticky; set when frame_tick arrives while busy
- timeout_err  out  1  sticky; set on any ack timeout

Behaviour:
- Reset values (rst_n=0 at a clock edge): state=IDLE; all outputs 0, including both col_state registers, col_x/col_y, overrun and timeout_err. first_sel=blue. Reset mid-sequence aborts it, and col_req is 0 from the next edge.
- FSM states: IDLE, Q1, W1, M1, Q2, W2, M2, DONE.
  - IDLE: frame_tick=1 and pause=0 -> Q1. frame_tick while paused is ignored and does not set overrun.
  - Qn: drive col_x/col_y for player n and set col_req=1; -> Wn.
  - Wn: col_req held at 1 with coordinates unchanged. On col_ack=1, latch col_state into that player's register and drop col_req -> Mn.
  - Wn timeout: wait counter reaches ACK_TIMEOUT with no ack -> latch 4'b1111 (freeze player), set timeout_err, drop col_req -> Mn.
  - Mn: pulse the player's move_en for one cycle; M1 -> Q2, M2 -> DONE.
  - DONE: frame_done=1 for one cycle; if ALTERNATE, toggle first_sel; -> IDLE.
- Latency: frame_tick at edge T gives col_req=1 at T+1. With ack on the first W cycle, frame_done is asserted at T+7.
- col_ack outside Wn is ignored, as is col_state.
- Player coordinates are sampled in Qn and held in registers; later changes to blue_x etc. do not affect an outstanding query.
- frame_tick while busy: tick is dropped and overrun is set (sticky until reset). A frame_tick on the same cycle as the DONE->IDLE transition counts as busy and is dropped.
- pause is sampled only in IDLE; a sequence in progress always completes.
- Wait counter: 5 bits, cleared on entry to each Wn, saturating. ACK_TIMEOUT must be at least 1.
- move_en pulses never overlap, and at most one is high in any cycle.

Decomposition:
- Shared package: state encoding enum; COL_UP/COL_DOWN/COL_RIGHT/COL_LEFT bit indices; COL_FREEZE=4'b1111; coordinate widths (X_W=10, Y_W=9).
- One natural sub-module, ack_timer: load/clear, count, timeout flag.

Test Plan:
- Single frame, ack 2 cycles after req, col_state 4'b0001 for blue, 4'b0100 for red -> blue_col_state=0001, red_col_state=0100; blue_move_en precedes red_move_en; one frame_done.
- ALTERNATE=1, three frames -> service order blue/red, red/blue, blue/red, checked by col_x values (blue_x=100, red_x=300).
- col_ack never asserted, ACK_TIMEOUT=16 -> col_req drops after 16 wait cycles; blue_col_state=1111; timeout_err=1; red still served.
- frame_tick pulsed in W1 -> overrun=1; the sequence completes normally; no extra frame is run.
- pause=1 with frame_tick -> stays IDLE, busy=0, no overrun. pause raised during W2 -> that frame completes.
- rst_n=0 during W1 with col_req=1 -> col_req=0 and all outputs 0 next edge; after release, the next frame_tick starts blue first.
